// File: rtl/qa_drv_mem_arbiter_pkg.sv
// Shared types and round-robin helpers for the qa_drv_memory client arbiter.
package qa_drv_mem_arbiter_pkg;

  localparam int unsigned N_CLIENTS = 4;
  localparam int unsigned CW        = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned CL_DATA_W = 512;

  typedef logic [CL_ADDR_W-1:0] t_cci_mpf_cl_vaddr;
  typedef logic [CL_DATA_W-1:0] t_cci_cldata;
  typedef logic [CW-1:0]        t_client_id;
  typedef logic [N_CLIENTS-1:0] t_client_mask;

  typedef struct packed {
    t_cci_mpf_cl_vaddr addr;
    logic              cached;
    logic              check_order;
  } t_rd_req;

  typedef struct packed {
    t_cci_mpf_cl_vaddr addr;
    t_cci_cldata       data;
    logic              cached;
    logic              check_order;
  } t_wr_req;

  // First set bit of valid at or after ptr, wrapping; returns a one-hot mask.
  function automatic t_client_mask rr_pick(input t_client_mask valid, input t_client_id ptr);
    t_client_mask grant;
    logic         found;
    int unsigned  idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      idx = (32'(ptr) + i) % N_CLIENTS;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic t_client_id onehot_to_id(input t_client_mask m);
    t_client_id id;
    id = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (m[i]) id = id | t_client_id'(i);
    end
    return id;
  endfunction

  function automatic t_client_mask id_to_mask(input t_client_id id);
    return t_client_mask'(1) << id;
  endfunction

endpackage

// File: rtl/qa_drv_mem_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module qa_drv_mem_rr_arb
  import qa_drv_mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  t_client_mask i_valid,
  input  logic         i_en,
  output t_client_mask o_grant_c,
  output t_client_id   o_grant_id_c
);

  t_client_id   r_ptr;
  t_client_id   w_ptr_nxt;
  t_client_mask w_grant;
  t_client_id   w_id;

  always_comb begin
    w_grant   = i_en ? rr_pick(i_valid, r_ptr) : '0;
    w_id      = onehot_to_id(w_grant);
    w_ptr_nxt = r_ptr;
    if (|w_grant) begin
      w_ptr_nxt = (32'(w_id) == N_CLIENTS - 1) ? '0 : w_id + t_client_id'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ptr <= '0;
    else          r_ptr <= w_ptr_nxt;
  end

  assign o_grant_c    = w_grant;
  assign o_grant_id_c = w_id;

endmodule

// File: rtl/qa_drv_small_fifo.sv
// Small synchronous FIFO; push when full and pop when empty are ignored.
module qa_drv_small_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_push;
  logic             w_pop;

  assign o_empty_c = (r_wr == r_rd);
  assign o_full_c  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push    = i_push && !o_full_c;
  assign w_pop     = i_pop && !o_empty_c;
  assign o_data_c  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/qa_drv_mem_arbiter.sv
// Shares qa_drv_memory read/write client ports among N_CLIENTS requesters with
// independent RR arbitration, in-order response routing and write-completion tracking.
module qa_drv_mem_arbiter
  import qa_drv_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_RD_OUTSTANDING = 64,
  parameter int unsigned MAX_WR_OUTSTANDING = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  t_client_mask      cl_rd_valid,
  input  t_cci_mpf_cl_vaddr cl_rd_addr [N_CLIENTS],
  input  t_client_mask      cl_rd_cached,
  input  t_client_mask      cl_rd_check_order,
  output t_client_mask      cl_rd_grant,
  output t_client_mask      cl_rd_rsp_valid,
  output t_cci_cldata       cl_rd_rsp_data,
  input  t_client_mask      cl_wr_valid,
  input  t_cci_mpf_cl_vaddr cl_wr_addr [N_CLIENTS],
  input  t_cci_cldata       cl_wr_data [N_CLIENTS],
  input  t_client_mask      cl_wr_cached,
  input  t_client_mask      cl_wr_check_order,
  output t_client_mask      cl_wr_grant,
  output logic              wr_idle,
  output logic              rsp_err,
  output t_cci_mpf_cl_vaddr mem_read_req_addr,
  output logic              mem_read_req_cached,
  output logic              mem_read_req_check_order,
  output logic              mem_read_req_enable,
  input  logic              mem_read_req_rdy,
  input  t_cci_cldata       mem_read_rsp_data,
  input  logic              mem_read_rsp_rdy,
  output t_cci_mpf_cl_vaddr mem_write_addr,
  output t_cci_cldata       mem_write_data,
  output logic              mem_write_req_cached,
  output logic              mem_write_req_check_order,
  output logic              mem_write_enable,
  input  logic              mem_write_rdy,
  input  logic [1:0]        mem_write_ack
);

  localparam int unsigned WCW = $clog2(MAX_WR_OUTSTANDING + 1);

  t_rd_req          r_rd_req;
  logic             r_rd_en;
  t_wr_req          r_wr_req;
  logic             r_wr_en;
  logic [WCW-1:0]   r_wr_cnt;
  logic             r_rsp_err;

  t_client_mask     w_rd_grant;
  t_client_id       w_rd_id;
  t_client_mask     w_wr_grant;
  t_client_id       w_wr_id;
  t_rd_req          w_rd_sel;
  t_wr_req          w_wr_sel;
  logic             w_rd_elig;
  logic             w_wr_elig;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  t_client_id       w_head_id;
  logic             w_pop;
  logic [WCW:0]     w_wr_sum;
  logic [WCW:0]     w_wr_cnt_nxt;

  // Grants are forced low while reset is asserted, independent of the clock.
  assign w_rd_elig = reset_n && mem_read_req_rdy && !w_fifo_full;
  assign w_wr_elig = reset_n && mem_write_rdy &&
                     (({1'b0, r_wr_cnt} + (WCW+1)'(r_wr_en)) < (WCW+1)'(MAX_WR_OUTSTANDING));

  qa_drv_mem_rr_arb u_rd_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (cl_rd_valid),
    .i_en         (w_rd_elig),
    .o_grant_c    (w_rd_grant),
    .o_grant_id_c (w_rd_id)
  );

  qa_drv_mem_rr_arb u_wr_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (cl_wr_valid),
    .i_en         (w_wr_elig),
    .o_grant_c    (w_wr_grant),
    .o_grant_id_c (w_wr_id)
  );

  qa_drv_small_fifo #(
    .WIDTH (CW),
    .DEPTH (MAX_RD_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (|w_rd_grant),
    .i_data    (w_rd_id),
    .i_pop     (mem_read_rsp_rdy),
    .o_data_c  (w_head_id),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty)
  );

  always_comb begin
    w_rd_sel             = '0;
    w_rd_sel.addr        = cl_rd_addr[w_rd_id];
    w_rd_sel.cached      = cl_rd_cached[w_rd_id];
    w_rd_sel.check_order = cl_rd_check_order[w_rd_id];
    w_wr_sel             = '0;
    w_wr_sel.addr        = cl_wr_addr[w_wr_id];
    w_wr_sel.data        = cl_wr_data[w_wr_id];
    w_wr_sel.cached      = cl_wr_cached[w_wr_id];
    w_wr_sel.check_order = cl_wr_check_order[w_wr_id];
  end

  // Width+1 arithmetic so two acks against one issue cannot wrap; underflow clamps to 0.
  always_comb begin
    w_wr_sum     = {1'b0, r_wr_cnt} + (WCW+1)'(r_wr_en);
    w_wr_cnt_nxt = '0;
    if (w_wr_sum >= (WCW+1)'(mem_write_ack)) begin
      w_wr_cnt_nxt = w_wr_sum - (WCW+1)'(mem_write_ack);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_req  <= '0;
      r_rd_en   <= 1'b0;
      r_wr_req  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_cnt  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rd_en  <= |w_rd_grant;
      r_wr_en  <= |w_wr_grant;
      r_wr_cnt <= w_wr_cnt_nxt[WCW-1:0];
      if (|w_rd_grant) r_rd_req <= w_rd_sel;
      if (|w_wr_grant) r_wr_req <= w_wr_sel;
      if (mem_read_rsp_rdy && w_fifo_empty) r_rsp_err <= 1'b1;
    end
  end

  assign w_pop           = mem_read_rsp_rdy && !w_fifo_empty;
  assign cl_rd_rsp_valid = w_pop ? id_to_mask(w_head_id) : '0;
  assign cl_rd_rsp_data  = w_pop ? mem_read_rsp_data : '0;

  assign cl_rd_grant               = w_rd_grant;
  assign cl_wr_grant               = w_wr_grant;
  assign mem_read_req_addr         = r_rd_req.addr;
  assign mem_read_req_cached       = r_rd_req.cached;
  assign mem_read_req_check_order  = r_rd_req.check_order;
  assign mem_read_req_enable       = r_rd_en;
  assign mem_write_addr            = r_wr_req.addr;
  assign mem_write_data            = r_wr_req.data;
  assign mem_write_req_cached      = r_wr_req.cached;
  assign mem_write_req_check_order = r_wr_req.check_order;
  assign mem_write_enable          = r_wr_en;
  assign wr_idle                   = (r_wr_cnt == '0) && !r_wr_en;
  assign rsp_err                   = r_rsp_err;

endmodule

// File: tb/tb_qa_drv_mem_arbiter.sv
// Bench for qa_drv_mem_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_qa_drv_mem_arbiter;
  import qa_drv_mem_arbiter_pkg::*;

  localparam int N      = int'(N_CLIENTS);
  localparam int RD_MAX = 64;
  localparam int WR_MAX = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  t_client_mask      cl_rd_valid, cl_rd_cached, cl_rd_check_order, cl_rd_grant, cl_rd_rsp_valid;
  t_cci_mpf_cl_vaddr cl_rd_addr [N_CLIENTS];
  t_cci_cldata       cl_rd_rsp_data;
  t_client_mask      cl_wr_valid, cl_wr_cached, cl_wr_check_order, cl_wr_grant;
  t_cci_mpf_cl_vaddr cl_wr_addr [N_CLIENTS];
  t_cci_cldata       cl_wr_data [N_CLIENTS];
  logic              wr_idle, rsp_err;
  t_cci_mpf_cl_vaddr mem_read_req_addr, mem_write_addr;
  logic              mem_read_req_cached, mem_read_req_check_order, mem_read_req_enable;
  logic              mem_read_req_rdy, mem_read_rsp_rdy;
  t_cci_cldata       mem_read_rsp_data, mem_write_data;
  logic              mem_write_req_cached, mem_write_req_check_order, mem_write_enable;
  logic              mem_write_rdy;
  logic [1:0]        mem_write_ack;

  always #5 clk = ~clk;

  qa_drv_mem_arbiter #(
    .MAX_RD_OUTSTANDING (RD_MAX),
    .MAX_WR_OUTSTANDING (WR_MAX)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .cl_rd_valid               (cl_rd_valid),
    .cl_rd_addr                (cl_rd_addr),
    .cl_rd_cached              (cl_rd_cached),
    .cl_rd_check_order         (cl_rd_check_order),
    .cl_rd_grant               (cl_rd_grant),
    .cl_rd_rsp_valid           (cl_rd_rsp_valid),
    .cl_rd_rsp_data            (cl_rd_rsp_data),
    .cl_wr_valid               (cl_wr_valid),
    .cl_wr_addr                (cl_wr_addr),
    .cl_wr_data                (cl_wr_data),
    .cl_wr_cached              (cl_wr_cached),
    .cl_wr_check_order         (cl_wr_check_order),
    .cl_wr_grant               (cl_wr_grant),
    .wr_idle                   (wr_idle),
    .rsp_err                   (rsp_err),
    .mem_read_req_addr         (mem_read_req_addr),
    .mem_read_req_cached       (mem_read_req_cached),
    .mem_read_req_check_order  (mem_read_req_check_order),
    .mem_read_req_enable       (mem_read_req_enable),
    .mem_read_req_rdy          (mem_read_req_rdy),
    .mem_read_rsp_data         (mem_read_rsp_data),
    .mem_read_rsp_rdy          (mem_read_rsp_rdy),
    .mem_write_addr            (mem_write_addr),
    .mem_write_data            (mem_write_data),
    .mem_write_req_cached      (mem_write_req_cached),
    .mem_write_req_check_order (mem_write_req_check_order),
    .mem_write_enable          (mem_write_enable),
    .mem_write_rdy             (mem_write_rdy),
    .mem_write_ack             (mem_write_ack)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int                m_rd_ptr, m_wr_ptr, m_wr_cnt;
  int                m_q[$];
  bit                m_rd_en, m_wr_en, m_err;
  t_cci_mpf_cl_vaddr m_rd_addr, m_wr_addr;
  t_cci_cldata       m_wr_data;
  bit                m_rd_cached, m_rd_co, m_wr_cached, m_wr_co;

  // Snapshots of DUT outputs taken at the compare point
  t_client_mask      s_rd_grant, s_wr_grant, s_rsp_valid;
  logic              s_wr_idle, s_rsp_err, s_rd_en, s_wr_en;
  t_cci_mpf_cl_vaddr s_rd_addr;

  int rd_prob = 0;
  int wr_prob = 0;
  bit fixed_addr = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic t_cci_cldata rand_cl();
    t_cci_cldata d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  function automatic int pick(input t_client_mask v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic new_rd(input int i);
    cl_rd_valid[i]       = 1'b1;
    cl_rd_addr[i]        = fixed_addr ? t_cci_mpf_cl_vaddr'(32'h100 + i)
                                      : t_cci_mpf_cl_vaddr'({$urandom, $urandom});
    cl_rd_cached[i]      = 1'($urandom_range(1));
    cl_rd_check_order[i] = 1'($urandom_range(1));
  endtask

  task automatic new_wr(input int i);
    cl_wr_valid[i]       = 1'b1;
    cl_wr_addr[i]        = t_cci_mpf_cl_vaddr'({$urandom, $urandom});
    cl_wr_data[i]        = rand_cl();
    cl_wr_cached[i]      = 1'($urandom_range(1));
    cl_wr_check_order[i] = 1'($urandom_range(1));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_ptr = 0; m_wr_ptr = 0; m_wr_cnt = 0;
    m_rd_en = 0; m_wr_en = 0; m_err = 0;
  endtask

  // One clock: compare at negedge, advance model, then clients react after posedge.
  task automatic cycle();
    int           rg, wg;
    bit           pop;
    t_client_mask erg, ewg, ersp;
    @(negedge clk);
    s_rd_grant = cl_rd_grant;  s_wr_grant = cl_wr_grant;  s_rsp_valid = cl_rd_rsp_valid;
    s_wr_idle  = wr_idle;      s_rsp_err  = rsp_err;
    s_rd_en    = mem_read_req_enable; s_wr_en = mem_write_enable; s_rd_addr = mem_read_req_addr;
    if (!reset_n) begin
      chk("rst_rd_grant", cl_rd_grant, 0);
      chk("rst_wr_grant", cl_wr_grant, 0);
      chk("rst_rsp_valid", cl_rd_rsp_valid, 0);
      chk("rst_rd_en", mem_read_req_enable, 0);
      chk("rst_wr_en", mem_write_enable, 0);
      chk("rst_wr_idle", wr_idle, 1);
      chk("rst_rsp_err", rsp_err, 0);
      model_reset();
    end else begin
      rg   = (mem_read_req_rdy && m_q.size() < RD_MAX) ? pick(cl_rd_valid, m_rd_ptr) : -1;
      wg   = (mem_write_rdy && (m_wr_cnt + int'(m_wr_en)) < WR_MAX) ? pick(cl_wr_valid, m_wr_ptr) : -1;
      erg  = (rg >= 0) ? t_client_mask'(1 << rg) : '0;
      ewg  = (wg >= 0) ? t_client_mask'(1 << wg) : '0;
      pop  = mem_read_rsp_rdy && (m_q.size() > 0);
      ersp = pop ? t_client_mask'(1 << m_q[0]) : '0;
      chk("rd_grant", cl_rd_grant, erg);
      chk("wr_grant", cl_wr_grant, ewg);
      chk("rsp_valid", cl_rd_rsp_valid, ersp);
      if (pop) chk("rsp_data", cl_rd_rsp_data, mem_read_rsp_data);
      chk("rd_en", mem_read_req_enable, m_rd_en);
      if (m_rd_en) begin
        chk("rd_addr", mem_read_req_addr, m_rd_addr);
        chk("rd_cached", mem_read_req_cached, m_rd_cached);
        chk("rd_order", mem_read_req_check_order, m_rd_co);
      end
      chk("wr_en", mem_write_enable, m_wr_en);
      if (m_wr_en) begin
        chk("wr_addr", mem_write_addr, m_wr_addr);
        chk("wr_data", mem_write_data, m_wr_data);
        chk("wr_cached", mem_write_req_cached, m_wr_cached);
        chk("wr_order", mem_write_req_check_order, m_wr_co);
      end
      chk("wr_idle", wr_idle, (m_wr_cnt == 0) && !m_wr_en);
      chk("rsp_err", rsp_err, m_err);
      if (mem_read_rsp_rdy && !pop) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (rg >= 0) begin
        m_q.push_back(rg);
        m_rd_ptr = (rg + 1) % N;
        m_rd_addr = cl_rd_addr[rg]; m_rd_cached = cl_rd_cached[rg]; m_rd_co = cl_rd_check_order[rg];
      end
      m_rd_en  = (rg >= 0);
      m_wr_cnt = m_wr_cnt + int'(m_wr_en) - int'(mem_write_ack);
      if (m_wr_cnt < 0) m_wr_cnt = 0;
      if (wg >= 0) begin
        m_wr_ptr = (wg + 1) % N;
        m_wr_addr = cl_wr_addr[wg]; m_wr_data = cl_wr_data[wg];
        m_wr_cached = cl_wr_cached[wg]; m_wr_co = cl_wr_check_order[wg];
      end
      m_wr_en = (wg >= 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_rd_grant[i]) cl_rd_valid[i] = 1'b0;
      if (s_wr_grant[i]) cl_wr_valid[i] = 1'b0;
      if (!cl_rd_valid[i] && $urandom_range(99) < rd_prob) new_rd(i);
      if (!cl_wr_valid[i] && $urandom_range(99) < wr_prob) new_wr(i);
    end
  endtask

  // Assert reset between edges, check outputs drop without a clock, release after two cycles.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_grant", cl_rd_grant, 0);
    chk("async_wr_grant", cl_wr_grant, 0);
    chk("async_rd_en", mem_read_req_enable, 0);
    chk("async_wr_en", mem_write_enable, 0);
    chk("async_wr_idle", wr_idle, 1);
    chk("async_rsp_err", rsp_err, 0);
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    t_client_mask g[5];
    t_cci_mpf_cl_vaddr a[5];
    logic e[5];
    int cnt, cnt2;

    reset_n = 1'b0;
    cl_rd_valid = '0; cl_rd_cached = '0; cl_rd_check_order = '0;
    cl_wr_valid = '0; cl_wr_cached = '0; cl_wr_check_order = '0;
    for (int i = 0; i < N; i++) begin
      cl_rd_addr[i] = '0; cl_wr_addr[i] = '0; cl_wr_data[i] = '0;
    end
    mem_read_req_rdy = 1'b1; mem_read_rsp_rdy = 1'b0; mem_read_rsp_data = rand_cl();
    mem_write_rdy = 1'b1; mem_write_ack = 2'd0;
    model_reset();
    @(posedge clk); #1;
    cycle(); cycle();
    chk("lit_reset_idle", s_wr_idle, 1);
    chk("lit_reset_err", s_rsp_err, 0);
    reset_n = 1'b1;

    // Four clients requesting continuously at 0x100+i
    fixed_addr = 1'b1; rd_prob = 100;
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      g[k] = s_rd_grant; a[k] = s_rd_addr; e[k] = s_rd_en;
    end
    chk("lit_rr_g0", g[0], 4'b0001);
    chk("lit_rr_g1", g[1], 4'b0010);
    chk("lit_rr_g2", g[2], 4'b0100);
    chk("lit_rr_g3", g[3], 4'b1000);
    chk("lit_rr_g4", g[4], 4'b0001);
    chk("lit_en_lag", {e[0], e[1]}, 2'b01);
    chk("lit_addr1", a[1], 42'h100);
    chk("lit_addr2", a[2], 42'h101);
    rd_prob = 0; cl_rd_valid = '0; mem_read_rsp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_read_rsp_data = rand_cl();
      cycle();
      g[k] = s_rsp_valid;
    end
    chk("lit_rsp0", g[0], 4'b0001);
    chk("lit_rsp1", g[1], 4'b0010);
    chk("lit_rsp2", g[2], 4'b0100);
    chk("lit_rsp3", g[3], 4'b1000);
    cycle();
    mem_read_rsp_rdy = 1'b0;
    fixed_addr = 1'b0;

    // ID FIFO fills at RD_MAX outstanding reads
    rd_prob = 100; cnt = 0;
    for (int k = 0; k < 70; k++) begin
      cycle();
      cnt += $countones(s_rd_grant);
    end
    chk("lit_fifo_full_cnt", cnt, RD_MAX);
    chk("lit_fifo_full_g", s_rd_grant, 0);
    mem_read_rsp_rdy = 1'b1;
    cycle();
    chk("lit_full_pop_nogrant", s_rd_grant, 0);
    chk("lit_full_pop_rsp", (s_rsp_valid != 0), 1);
    mem_read_rsp_rdy = 1'b0;
    cycle();
    chk("lit_full_resume", (s_rd_grant != 0), 1);
    rd_prob = 0; cl_rd_valid = '0; mem_read_rsp_rdy = 1'b1;
    repeat (70) cycle();
    mem_read_rsp_rdy = 1'b0;

    // Reset with five reads outstanding, then stale responses
    rd_prob = 100; cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      cnt += $countones(s_rd_grant);
    end
    chk("lit_burst_cnt", cnt, 5);
    async_reset();
    cycle();
    chk("lit_ptr_restart", s_rd_grant, 4'b0001);
    rd_prob = 0; cl_rd_valid = '0; mem_read_rsp_rdy = 1'b1;
    cycle();
    chk("lit_post_rst_rsp", s_rsp_valid, 4'b0001);
    cycle();
    chk("lit_empty_rsp", s_rsp_valid, 0);
    mem_read_rsp_rdy = 1'b0;
    cycle();
    chk("lit_err_set", s_rsp_err, 1);
    repeat (3) cycle();
    chk("lit_err_sticky", s_rsp_err, 1);

    // Read channel stalled by mem_read_req_rdy
    mem_read_req_rdy = 1'b0;
    new_rd(1); new_rd(3);
    async_reset();
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      cnt += $countones(s_rd_grant);
      cnt2 += int'(s_rd_en);
    end
    chk("lit_stall_grants", cnt, 0);
    chk("lit_stall_en", cnt2, 0);
    mem_read_req_rdy = 1'b1;
    cycle();
    chk("lit_stall_g1", s_rd_grant, 4'b0010);
    cycle();
    chk("lit_stall_g3", s_rd_grant, 4'b1000);

    // Write counter: three issued, fourth issue with two acks, then two more acks
    async_reset();
    for (int i = 0; i < N; i++) new_wr(i);
    for (int k = 0; k < 4; k++) begin
      cycle();
      g[k] = s_wr_grant;
    end
    chk("lit_wr_g0", g[0], 4'b0001);
    chk("lit_wr_g3", g[3], 4'b1000);
    mem_write_ack = 2'd2;
    cycle();
    chk("lit_wr_en4", s_wr_en, 1);
    cycle();
    chk("lit_wr_cnt2_busy", s_wr_idle, 0);
    mem_write_ack = 2'd0;
    cycle();
    chk("lit_wr_idle", s_wr_idle, 1);
    mem_write_ack = 2'd2;
    cycle();
    mem_write_ack = 2'd0;
    cycle();
    chk("lit_wr_underflow_idle", s_wr_idle, 1);

    // Write cap at WR_MAX unacknowledged
    wr_prob = 100; cnt = 0;
    for (int k = 0; k < 140; k++) begin
      cycle();
      cnt += $countones(s_wr_grant);
    end
    chk("lit_wr_cap_cnt", cnt, WR_MAX);
    chk("lit_wr_cap_g", s_wr_grant, 0);
    wr_prob = 0; cl_wr_valid = '0; mem_write_ack = 2'd2;
    repeat (70) cycle();
    mem_write_ack = 2'd0;
    cycle();
    chk("lit_wr_drained", s_wr_idle, 1);

    // Randomized traffic with one reset mid-stream
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        rd_prob = $urandom_range(100);
        wr_prob = $urandom_range(100);
      end
      mem_read_req_rdy  = ($urandom_range(9) < 8);
      mem_read_rsp_rdy  = ($urandom_range(9) < 4);
      mem_write_rdy     = ($urandom_range(9) < 8);
      mem_write_ack     = ($urandom_range(9) < 6) ? 2'd0 : 2'($urandom_range(1, 2));
      mem_read_rsp_data = rand_cl();
      if (c == 700) async_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qa_drv_mem_arbiter.md
Name: qa_drv_mem_arbiter

Overview:
- Shares the single read-request, write-request and read-response client ports of qa_drv_memory among N_CLIENTS requesters.
- Uses independent round-robin arbitration for the read and write channels.
- Routes in-order read responses back to the issuing client through a client-ID FIFO.
- Tracks outstanding writes from the aggregate mem_write_ack pulses, so clients can fence on write completion.
- Sits between the LEAP-side memory clients and qa_drv_memory; SORT_READ_RESPONSES=1 guarantees response order.

Parameters:
N_CLIENTS, 4, number of requesters (2..8); CW = $clog2(N_CLIENTS)
MAX_RD_OUTSTANDING, 64, depth of read client-ID FIFO; power of two
MAX_WR_OUTSTANDING, 128, cap on unacknowledged writes; counter width $clog2(MAX+1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cl_rd_valid  in  N  client read request valid
cl_rd_addr  in  N x t_cci_mpf_cl_vaddr  read line address
cl_rd_cached  in  N  use CCI cache
cl_rd_check_order  in  N  enforce load/store order
cl_rd_grant  out  N  one-hot; request accepted this cycle
cl_rd_rsp_valid  out  N  one-hot response strobe
cl_rd_rsp_data  out  t_cci_cldata  response data, shared by all clients
cl_wr_valid  in  N  client write valid
cl_wr_addr  in  N x t_cci_mpf_cl_vaddr  write line address
cl_wr_data  in  N x t_cci_cldata  write data
cl_wr_cached  in  N  use CCI cache
cl_wr_check_order  in  N  enforce order
cl_wr_grant  out  N  one-hot; write accepted this cycle
wr_idle  out  1  no writes outstanding or staged
rsp_err  out  1  sticky; response arrived with ID FIFO empty
mem_read_req_addr/_cached/_check_order/_enable  out  as qa_drv_memory  registered issue stage
mem_read_req_rdy  in  1
mem_read_rsp_data  in  t_cci_cldata
mem_read_rsp_rdy  in  1
mem_write_addr/_data/_req_cached/_req_check_order/_enable  out  as qa_drv_memory  registered issue stage
mem_write_rdy  in  1
mem_write_ack  in  2  writes completed this cycle (0..2)

Behaviour:
- Reset (async assert, sync release):
  - All grants, rsp_valid, mem_*_enable and rsp_err are 0; wr_idle=1.
  - RR pointers are 0; ID FIFO is empty; write counter is 0.
  - Reset mid-operation discards in-flight bookkeeping. Later responses raise rsp_err; later acks saturate the counter at 0.
- Read arbitration (combinational grant):
  - Eligible when mem_read_req_rdy=1 and the ID FIFO is not full.
  - Grant goes to the first valid client at or after rd_ptr (wrapping at N_CLIENTS).
  - On grant, rd_ptr <= granted+1 mod N.
  - A client holds valid and request fields until its grant.
- Read issue:
  - Granted request is registered into the mem_read_* outputs; mem_read_req_enable=1 exactly one cycle after the grant.
  - The granted ID is pushed to the FIFO in the same cycle.
  - The almost-full slack of mem_read_req_rdy absorbs the 1-cycle stage; enable is never issued while rdy=0 from the grant cycle.
- Read response:
  - On mem_read_rsp_rdy, pop the FIFO and drive cl_rd_rsp_valid[id]=1 and cl_rd_rsp_data in the same cycle (combinational, 0 latency).
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Pop on empty: no strobe, rsp_err<=1.
- Write arbitration: identical RR with a separate wr_ptr. Eligible when mem_write_rdy=1 and wr_cnt + staged < MAX_WR_OUTSTANDING. Same 1-cycle issue stage.
- Write counter:
  - wr_cnt_next = wr_cnt + mem_write_enable − mem_write_ack, computed at width+1.
  - Simultaneous issue and 2 acks give net −1.
  - An underflow clamps to 0.
  - wr_idle = (wr_cnt==0) && !mem_write_enable && !any staged write.
- Read and write channels are fully independent; both may grant in the same cycle, including to the same client.

Decomposition:
- Package qa_drv_mem_arbiter_pkg: N_CLIENTS default, t_client_id (CW bits), t_client_mask, and function rr_pick(valid, ptr) returning a one-hot mask.
- Sub-module qa_drv_mem_rr_arb (valid mask, enable, ptr state, one-hot grant) is instantiated twice, once for reads and once for writes.
- The ID FIFO uses the codebase's existing small-FIFO primitive.

Test Plan:
- Reads, all 4 clients valid continuously at addrs 0x100+i, rdy=1 → grants cycle 0,1,2,3,0…; enable follows 1 cycle later; 4 in-order responses strobe rsp_valid in order 0,1,2,3.
- FIFO full: 64 reads issued with no responses → grant=0 on the 65th. One response that cycle frees a slot; the grant resumes on the next cycle.
- mem_read_req_rdy=0 for 10 cycles with 2 clients valid → no grants and no enable; when rdy rises, the grant goes to the pointer-next client.
- Writes: 3 writes issued, then mem_write_ack=2 coincident with a 4th issue → wr_cnt goes 3→2. A following ack=2 gives 0 and wr_idle=1 one cycle after the last enable.
- Response with empty FIFO after reset → no rsp_valid; rsp_err=1 and stays set until reset.
- reset_n asserted mid-burst (5 reads outstanding) → all outputs 0 asynchronously; after release the pointers restart at client 0.
